md_unit_e: RTL and testbench
============================

// Module: md_unit_e
// PURPOSE
//  Multiply/divide unit of the E stage. Accepts MULT/MULTU/DIV/DIVU from the E-stage decode.
//  Holds the architectural HI/LO registers and serves MFHI/MFLO via rd_data.
//  rd_data is the value that travels down the pipe to the M stage as HILO_M.
//  Also executes MTHI/MTLO.
//  Raises a stall request to the D stage while an operation is in flight.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  reset      in   1   asynchronous, active-low: 0 clears all state immediately
//  start      in   1   E-stage instr is a valid MD op this cycle
//  op         in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, others = no-op
//  a          in   32  rs operand (forwarded)
//  b          in   32  rt operand (forwarded)
//  rd_sel     in   1   0 = read LO, 1 = read HI
//  d_md_use   in   1   D-stage instr is MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO
//  busy       out  1   registered; operation in flight
//  stall_req  out  1   combinational: d_md_use & (busy | start_op)
//  rd_data    out  32  combinational: rd_sel ? HI : LO (committed values only)
//  hi, lo     out  32  architectural HI/LO (debug)
// BEHAVIOUR
//  Reset (reset==0, async): busy=0; count=0; HI=LO=0; pending result=0.
//   Reset mid-operation abandons the op; HI/LO stay 0.
//  start_op = start & op in {0..3}; start_mt = start & op in {4,5}.
//  States: IDLE (busy=0), RUN (busy=1, down-counter count).
//  IDLE, start_op at edge t0:
//   - compute the 64-bit result from a/b and latch it into pending {ph,pl};
//   - count <= N-1 (N = MULT_CYCLES or DIV_CYCLES);
//   - busy <= 1.
//  RUN, each edge: if count != 0, count--. If count == 0: HI <= ph, LO <= pl, busy <= 0.
//   Net effect: busy is high for exactly N cycles after t0.
//   HI/LO are visible on rd_data in the cycle after busy falls.
//  MULT: {HI,LO} = signed(a)*signed(b). MULTU: same, unsigned; full 64-bit product.
//  DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of a.
//  DIVU: same, unsigned.
//  Divide by zero (b==0): LO = 32'hFFFF_FFFF, HI = a (both signed and unsigned).
//  DIV with a=32'h8000_0000, b=32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0.
//  MTHI/MTLO in IDLE: HI or LO <= a at the edge. Readable via rd_data the next cycle.
//  Illegal start while RUN (start_op or start_mt):
//   - ignored; no state change;
//   - must never occur under a correct stall; the bench flags it with an assertion.
//  rd_data during RUN returns the old HI/LO. MFHI/MFLO cannot reach E during RUN because of stall_req.
//  Ops 6/7: no effect.
//  Back-to-back ops: a new start_op is accepted in the cycle busy is 0, i.e. the cycle after completion.
// TESTING
//  1. Reset: reset=0 mid-RUN of DIV -> busy=0 immediately; hi=lo=0; rd_data=0.
//  2. MULT a=32'hFFFF_FFFE (-2), b=3 -> busy high exactly 5 cycles; then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
//  3. MULTU a=b=32'hFFFF_FFFF -> HI=32'hFFFF_FFFE, LO=32'h0000_0001.
//  4. DIV a=-7, b=2 -> busy 10 cycles; LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1).
//     DIVU a=7, b=0 -> LO=32'hFFFF_FFFF, HI=7.
//  5. Stall: d_md_use=1 during start cycle and all busy cycles -> stall_req=1.
//     Drops in the cycle busy=0. d_md_use=0 -> stall_req=0 throughout.
//  6. MTLO a=32'h1234_5678, then MFLO (rd_sel=0) next cycle -> rd_data=32'h1234_5678.
//     MTHI issued while busy -> HI unchanged and assertion fires.

Source files
------------

// File: rtl/md_unit_e.sv
// Multiply/divide unit for the E stage.
// Owns the architectural HI/LO registers. MULT/MULTU/DIV/DIVU compute their
// 64-bit result up front into a pending register, then hold busy for a fixed
// number of cycles before committing it to HI/LO. MTHI/MTLO write directly
// when idle. A D-stage stall is requested while an operation is in flight.
module md_unit_e #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_sel,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic [31:0]   hi_reg, hi_next;
    logic [31:0]   lo_reg, lo_next;
    logic [31:0]   ph_reg, ph_next;
    logic [31:0]   pl_reg, pl_next;

    logic          start_op;
    logic          start_mt;
    logic [63:0]   mul_s;
    logic [63:0]   mul_u;
    logic          div_signed;
    logic          a_neg;
    logic          b_neg;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic [31:0]   b_div;
    logic [31:0]   uq;
    logic [31:0]   ur;
    logic [31:0]   quot;
    logic [31:0]   rem;
    logic [63:0]   result;

    assign start_op  = start & (op[2] == 1'b0);
    assign start_mt  = start & ((op == 3'd4) | (op == 3'd5));

    assign busy      = (state_reg == RUN);
    assign stall_req = d_md_use & (busy | start_op);
    assign rd_data   = rd_sel ? hi_reg : lo_reg;
    assign hi        = hi_reg;
    assign lo        = lo_reg;

    // Datapath: full 64-bit products and a sign-magnitude divider shared by DIV/DIVU.
    // The most-negative / -1 case falls out of the magnitude path naturally
    // (quotient 0x8000_0000, remainder 0); divide-by-zero is overridden explicitly.
    always_comb begin
        mul_s      = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        mul_u      = {32'd0, a} * {32'd0, b};
        div_signed = (op == 3'd2);
        a_neg      = div_signed & a[31];
        b_neg      = div_signed & b[31];
        a_mag      = a_neg ? (~a + 32'd1) : a;
        b_mag      = b_neg ? (~b + 32'd1) : b;
        b_div      = (b == 32'd0) ? 32'd1 : b_mag;
        uq         = a_mag / b_div;
        ur         = a_mag % b_div;
        quot       = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        rem        = a_neg ? (~ur + 32'd1) : ur;
        if (b == 32'd0) begin
            quot = 32'hFFFF_FFFF;
            rem  = a;
        end
        case (op)
            3'd0:    result = mul_s;
            3'd1:    result = mul_u;
            default: result = {rem, quot};
        endcase
    end

    // Next-state logic: accept ops/moves only when idle; count down and commit in RUN.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        ph_next    = ph_reg;
        pl_next    = pl_reg;
        case (state_reg)
            IDLE: begin
                if (start_op) begin
                    ph_next    = result[63:32];
                    pl_next    = result[31:0];
                    count_next = op[1] ? DIV_LOAD : MULT_LOAD;
                    state_next = RUN;
                end else if (start_mt) begin
                    if (op == 3'd4) hi_next = a;
                    else            lo_next = a;
                end
            end
            RUN: begin
                if (count_reg != '0) begin
                    count_next = count_reg - 1'b1;
                end else begin
                    hi_next    = ph_reg;
                    lo_next    = pl_reg;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            ph_reg    <= 32'd0;
            pl_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            ph_reg    <= ph_next;
            pl_reg    <= pl_next;
        end
    end

endmodule

// File: tb/tb_md_unit_e.sv
// Directed bench for md_unit_e with a scoreboard of expected {HI,LO} results.
module tb_md_unit_e;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_sel;
    logic        d_md_use;
    logic        busy;
    logic        stall_req;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    int          illegal_cnt = 0;
    logic [63:0] sb[$];

    md_unit_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .rd_sel    (rd_sel),
        .d_md_use  (d_md_use),
        .busy      (busy),
        .stall_req (stall_req),
        .rd_data   (rd_data),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // Protocol checker: a start of any MD/MT op while busy is an illegal issue.
    always @(posedge clk) begin
        if (reset === 1'b1 && busy === 1'b1 && start === 1'b1 && op <= 3'd5) begin
            illegal_cnt++;
            $display("protocol: start issued while busy at %0t (op=%0d)", $time, op);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one MD op at the current negedge, follow busy, then score the result.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [63:0] exp, input int n,
                          input logic use_d, input int inject);
        int          cnt;
        int          guard;
        logic [31:0] hi_before;
        logic [63:0] e;
        hi_before = hi;
        start = 1'b1; op = o; a = av; b = bv; d_md_use = use_d;
        sb.push_back(exp);
        #1;
        chk({tag, "_stall_start"}, {63'd0, stall_req}, {63'd0, use_d});
        chk({tag, "_idle_before"}, {63'd0, busy}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 40) begin
            cnt++;
            chk({tag, "_stall_busy"}, {63'd0, stall_req}, {63'd0, use_d});
            if (cnt == inject + 1 && inject >= 0) begin
                chk({tag, "_illegal_hi_kept"}, {32'd0, hi}, {32'd0, hi_before});
                chk({tag, "_illegal_flagged"}, 64'(illegal_cnt), 64'd1);
            end
            if (cnt == inject) begin
                start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        chk({tag, "_busy_timeout"}, {63'd0, busy}, 64'd0);
        chk({tag, "_busy_cycles"}, 64'(cnt), 64'(n));
        chk({tag, "_stall_drop"}, {63'd0, stall_req}, 64'd0);
        e = sb.pop_front();
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
        rd_sel = 1'b0; #1;
        chk({tag, "_rd_lo"}, {32'd0, rd_data}, {32'd0, e[31:0]});
        rd_sel = 1'b1; #1;
        chk({tag, "_rd_hi"}, {32'd0, rd_data}, {32'd0, e[63:32]});
        d_md_use = 1'b0;
        $display("op %s: op=%0d a=%h b=%h busy_cycles=%0d hi=%h lo=%h", tag, o, av, bv, cnt, hi, lo);
    endtask

    // MTHI/MTLO in idle, read back through rd_data the following cycle.
    task automatic move_to(input string tag, input logic [2:0] o, input logic [31:0] av);
        @(negedge clk);
        start = 1'b1; op = o; a = av;
        @(negedge clk);
        start = 1'b0;
        rd_sel = (o == 3'd4);
        #1;
        chk({tag, "_rd"}, {32'd0, rd_data}, {32'd0, av});
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        $display("move %s: op=%0d a=%h rd_data=%h", tag, o, av, rd_data);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        rd_sel = 1'b0; d_md_use = 1'b0;
        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_rd", {32'd0, rd_data}, 64'd0);
        chk("rst_stall", {63'd0, stall_req}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Back-to-back ops: each starts in the cycle busy is low.
        run_op("mult_m2x3",  3'd0, 32'hFFFF_FFFE, 32'd3,         {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 5,  1'b1, -1);
        run_op("multu_max",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 5,  1'b0, -1);
        run_op("div_m7_2",   3'd2, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, 1'b1, -1);
        run_op("divu_7_0",   3'd3, 32'd7,         32'd0,         {32'd7,         32'hFFFF_FFFF}, 10, 1'b0, -1);
        run_op("div_ovf",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0,         32'h8000_0000}, 10, 1'b1, -1);
        run_op("div_m5_0",   3'd2, 32'hFFFF_FFFB, 32'd0,         {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 10, 1'b0, -1);
        run_op("divu_100_7", 3'd3, 32'd100,       32'd7,         {32'd2,         32'd14},        10, 1'b1, -1);

        move_to("mtlo", 3'd5, 32'h1234_5678);
        move_to("mthi", 3'd4, 32'hCAFE_F00D);
        chk("mthi_lo_kept", {32'd0, lo}, {32'd0, 32'h1234_5678});

        // Reserved op: no busy, no stall, no register change.
        @(negedge clk);
        start = 1'b1; op = 3'd6; a = 32'h5555_AAAA; d_md_use = 1'b1;
        #1;
        chk("op6_stall", {63'd0, stall_req}, 64'd0);
        @(negedge clk);
        start = 1'b0; d_md_use = 1'b0;
        chk("op6_busy", {63'd0, busy}, 64'd0);
        chk("op6_hilo", {hi, lo}, {32'hCAFE_F00D, 32'h1234_5678});
        $display("noop op=6: busy=%0d hi=%h lo=%h", busy, hi, lo);

        // MULT with an illegal MTHI injected on its second busy cycle.
        run_op("mult_7xm3", 3'd0, 32'd7, 32'hFFFF_FFFD, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 5, 1'b1, 2);
        chk("illegal_total", 64'(illegal_cnt), 64'd1);

        // Asynchronous reset in the middle of a DIV.
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
        sb.push_back({32'd1, 32'd33});
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstrun_busy_pre", {63'd0, busy}, 64'd1);
        #2 reset = 1'b0;
        #1;
        sb.delete();
        chk("rstrun_busy", {63'd0, busy}, 64'd0);
        chk("rstrun_hi", {32'd0, hi}, 64'd0);
        chk("rstrun_lo", {32'd0, lo}, 64'd0);
        chk("rstrun_rd", {32'd0, rd_data}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("rstrun_abandon_busy", {63'd0, busy}, 64'd0);
        chk("rstrun_abandon_hilo", {hi, lo}, 64'd0);
        $display("reset mid-div: busy=%0d hi=%h lo=%h", busy, hi, lo);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
